// File: rtl/camera_pixel_framer_pkg.sv
// Shared definitions for the camera pixel framer: FSM states, beat flag layout and default widths.
// FIFO beat word layout, MSB first: {frame_start, frame_stop, line_start, line_stop, y, x, data}.
package camera_pixel_framer_pkg;

   localparam int unsigned PIXEL_WIDTH_DEF     = 10;
   localparam int unsigned COORD_WIDTH_DEF     = 10;
   localparam int unsigned FIFO_DEPTH_LOG2_DEF = 4;
   localparam int unsigned FRAME_COUNT_WIDTH   = 16;
   localparam int unsigned FLAG_WIDTH          = 4;

   // Flag bit positions relative to the base of the flag field
   localparam int unsigned FLAG_LINE_STOP   = 0;
   localparam int unsigned FLAG_LINE_START  = 1;
   localparam int unsigned FLAG_FRAME_STOP  = 2;
   localparam int unsigned FLAG_FRAME_START = 3;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_IN_FRAME   = 2'd2,
      ST_DROP       = 2'd3
   } state_e;

   typedef struct packed {
      logic frame_start;
      logic frame_stop;
      logic line_start;
      logic line_stop;
   } beat_flags_t;

   function automatic int unsigned beat_width(input int unsigned pw, input int unsigned cw);
      return FLAG_WIDTH + 2 * cw + pw;
   endfunction

endpackage

// File: rtl/camera_pixel_fifo.sv
// Synchronous FIFO with show-ahead read data, occupancy count and full/empty decode.
module camera_pixel_fifo #(
   parameter int unsigned Width     = 8,
   parameter int unsigned DepthLog2 = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic [Width-1:0]     push_data,
   input  logic                 pop,
   output logic [Width-1:0]     pop_data_c,
   output logic                 full_c,
   output logic                 empty_c,
   output logic [DepthLog2:0]   count
);

   localparam int unsigned Depth = 1 << DepthLog2;

   logic [Width-1:0]     mem_q [Depth];
   logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DepthLog2:0]   count_q, count_d;
   logic                 do_push_c, do_pop_c;

   assign full_c     = (count_q == (DepthLog2 + 1)'(Depth));
   assign empty_c    = (count_q == '0);
   assign do_push_c  = push && !full_c;
   assign do_pop_c   = pop && !empty_c;
   assign pop_data_c = mem_q[rd_ptr_q];
   assign count      = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + DepthLog2'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + DepthLog2'(1);
      count_d = count_q + (DepthLog2 + 1)'(do_push_c) - (DepthLog2 + 1)'(do_pop_c);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read
   always_ff @(posedge clock) begin
      if (do_push_c) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/camera_pixel_framer.sv
// Converts level-framed camera timing into a ready/valid pixel stream with coordinates and
// frame/line flags, buffered in a FIFO, plus line/frame measurements and a sticky overflow flag.
module camera_pixel_framer
   import camera_pixel_framer_pkg::*;
#(
   parameter int unsigned PixelWidth      = PIXEL_WIDTH_DEF,
   parameter int unsigned CoordinateWidth = COORD_WIDTH_DEF,
   parameter int unsigned FifoDepthLog2   = FIFO_DEPTH_LOG2_DEF
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         in_vs,
   input  logic                         in_hs,
   input  logic                         in_valid,
   input  logic [PixelWidth-1:0]        in_d,
   output logic [PixelWidth-1:0]        out_data,
   output logic [CoordinateWidth-1:0]   out_x,
   output logic [CoordinateWidth-1:0]   out_y,
   output logic                         out_frame_start,
   output logic                         out_frame_stop,
   output logic                         out_line_start,
   output logic                         out_line_stop,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CoordinateWidth-1:0]   line_width,
   output logic [CoordinateWidth-1:0]   frame_height,
   output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
   output logic                         overflow,
   input  logic                         clear_overflow
);

   localparam int unsigned BeatWidth = beat_width(PixelWidth, CoordinateWidth);
   localparam int unsigned FlagBase  = 2 * CoordinateWidth + PixelWidth;
   localparam int unsigned FifoDepth = 1 << FifoDepthLog2;
   localparam int unsigned OccWidth  = FifoDepthLog2 + 2;
   localparam int unsigned CW        = CoordinateWidth;

   state_e                         state_q, state_d;
   logic                           vs_q, hs_q;
   logic                           vs_rise_c, vs_fall_c, hs_rise_c, hs_fall_c;
   logic                           hold_valid_q, hold_valid_d;
   logic [BeatWidth-1:0]           hold_word_q, hold_word_d;
   logic [CW-1:0]                  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, x_cur_c, y_cur_c;
   logic                           line_used_q, line_used_d;
   logic                           line_pend_q, line_pend_d;
   logic                           frame_pend_q, frame_pend_d;
   logic [CW-1:0]                  line_width_q, line_width_d;
   logic [CW-1:0]                  frame_height_q, frame_height_d;
   logic [FRAME_COUNT_WIDTH-1:0]   frame_count_q, frame_count_d;
   logic                           overflow_q, overflow_d;
   logic                           out_valid_q, out_valid_d;
   logic [BeatWidth-1:0]           out_word_q, out_word_d;
   logic                           accept_c, start_c, push_c, ovf_c, commit_c, load_c, full_c;
   logic [BeatWidth-1:0]           push_word_c, new_word_c, fifo_rdata_c;
   logic                           fifo_full_c, fifo_empty_c;
   logic [FifoDepthLog2:0]         fifo_count;
   logic [OccWidth-1:0]            occupancy_c;
   beat_flags_t                    new_flags_c;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   assign vs_rise_c = in_vs && !vs_q;
   assign vs_fall_c = !in_vs && vs_q;
   assign hs_rise_c = in_hs && !hs_q;
   assign hs_fall_c = !in_hs && hs_q;

   assign start_c  = (state_q == ST_WAIT_FRAME) && vs_rise_c && enable;
   assign accept_c = (state_q == ST_IN_FRAME) && in_vs && in_hs && in_valid;
   assign push_c   = (state_q == ST_IN_FRAME) && hold_valid_q && (accept_c || vs_fall_c);

   // Occupancy includes the output register so the total buffered beats never exceed FifoDepth
   assign occupancy_c = OccWidth'(fifo_count) + OccWidth'(out_valid_q);
   assign full_c      = fifo_full_c || (occupancy_c >= OccWidth'(FifoDepth));
   assign ovf_c       = push_c && full_c;
   assign commit_c    = push_c && !full_c;
   assign load_c      = !fifo_empty_c && (!out_valid_q || out_ready);

   // A pixel arriving with the hs rise belongs to the new line
   assign x_cur_c = hs_rise_c ? '0 : x_cnt_q;
   assign y_cur_c = (hs_rise_c && line_used_q) ? sat_inc(y_cnt_q) : y_cnt_q;

   assign new_flags_c = '{frame_start: frame_pend_q, frame_stop: 1'b0,
                          line_start: line_pend_q | hs_rise_c, line_stop: 1'b0};
   assign new_word_c  = {new_flags_c, y_cur_c, x_cur_c, in_d};

   always_comb begin
      push_word_c = hold_word_q;
      if (vs_fall_c) begin
         push_word_c[FlagBase + FLAG_LINE_STOP]  = 1'b1;
         push_word_c[FlagBase + FLAG_FRAME_STOP] = 1'b1;
      end
   end

   camera_pixel_fifo #(
      .Width     (BeatWidth),
      .DepthLog2 (FifoDepthLog2)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (commit_c),
      .push_data  (push_word_c),
      .pop        (load_c),
      .pop_data_c (fifo_rdata_c),
      .full_c     (fifo_full_c),
      .empty_c    (fifo_empty_c),
      .count      (fifo_count)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (enable && !in_vs) state_d = ST_WAIT_FRAME;
         ST_WAIT_FRAME: if (vs_rise_c) state_d = enable ? ST_IN_FRAME : ST_IDLE;
         ST_IN_FRAME: begin
            if (vs_fall_c)  state_d = enable ? ST_WAIT_FRAME : ST_IDLE;
            else if (ovf_c) state_d = ST_DROP;
         end
         ST_DROP:       if (vs_fall_c) state_d = enable ? ST_WAIT_FRAME : ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hold_valid_d   = hold_valid_q;
      hold_word_d    = hold_word_q;
      x_cnt_d        = x_cnt_q;
      y_cnt_d        = y_cnt_q;
      line_used_d    = line_used_q;
      line_pend_d    = line_pend_q;
      frame_pend_d   = frame_pend_q;
      line_width_d   = line_width_q;
      frame_height_d = frame_height_q;
      frame_count_d  = frame_count_q;
      overflow_d     = (overflow_q && !clear_overflow) || ovf_c;
      out_valid_d    = load_c || (out_valid_q && !out_ready);
      out_word_d     = load_c ? fifo_rdata_c : out_word_q;

      if (start_c) begin
         hold_valid_d = 1'b0;
         x_cnt_d      = '0;
         y_cnt_d      = '0;
         line_used_d  = 1'b0;
         line_pend_d  = 1'b1;
         frame_pend_d = 1'b1;
      end

      if (state_q == ST_IN_FRAME) begin
         if (hs_rise_c) begin
            x_cnt_d     = '0;
            y_cnt_d     = y_cur_c;
            line_used_d = 1'b0;
            line_pend_d = 1'b1;
         end
         if (hs_fall_c && hold_valid_q) hold_word_d[FlagBase + FLAG_LINE_STOP] = 1'b1;
         if (accept_c) begin
            hold_word_d  = new_word_c;
            hold_valid_d = 1'b1;
            x_cnt_d      = sat_inc(x_cur_c);
            y_cnt_d      = y_cur_c;
            line_used_d  = 1'b1;
            line_pend_d  = 1'b0;
            frame_pend_d = 1'b0;
         end
         if (vs_fall_c || ovf_c) hold_valid_d = 1'b0;
      end

      // Measurements only follow beats that actually reached the FIFO
      if (commit_c) begin
         if (push_word_c[FlagBase + FLAG_LINE_STOP])
            line_width_d = sat_inc(push_word_c[PixelWidth +: CW]);
         if (push_word_c[FlagBase + FLAG_FRAME_STOP]) begin
            frame_height_d = sat_inc(push_word_c[PixelWidth + CW +: CW]);
            frame_count_d  = frame_count_q + FRAME_COUNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vs_q           <= 1'b0;
         hs_q           <= 1'b0;
         hold_valid_q   <= 1'b0;
         hold_word_q    <= '0;
         x_cnt_q        <= '0;
         y_cnt_q        <= '0;
         line_used_q    <= 1'b0;
         line_pend_q    <= 1'b0;
         frame_pend_q   <= 1'b0;
         line_width_q   <= '0;
         frame_height_q <= '0;
         frame_count_q  <= '0;
         overflow_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         out_word_q     <= '0;
      end else begin
         vs_q           <= in_vs;
         hs_q           <= in_hs;
         hold_valid_q   <= hold_valid_d;
         hold_word_q    <= hold_word_d;
         x_cnt_q        <= x_cnt_d;
         y_cnt_q        <= y_cnt_d;
         line_used_q    <= line_used_d;
         line_pend_q    <= line_pend_d;
         frame_pend_q   <= frame_pend_d;
         line_width_q   <= line_width_d;
         frame_height_q <= frame_height_d;
         frame_count_q  <= frame_count_d;
         overflow_q     <= overflow_d;
         out_valid_q    <= out_valid_d;
         out_word_q     <= out_word_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_data        = out_word_q[PixelWidth-1:0];
   assign out_x           = out_word_q[PixelWidth +: CW];
   assign out_y           = out_word_q[PixelWidth + CW +: CW];
   assign out_frame_start = out_word_q[FlagBase + FLAG_FRAME_START];
   assign out_frame_stop  = out_word_q[FlagBase + FLAG_FRAME_STOP];
   assign out_line_start  = out_word_q[FlagBase + FLAG_LINE_START];
   assign out_line_stop   = out_word_q[FlagBase + FLAG_LINE_STOP];
   assign line_width      = line_width_q;
   assign frame_height    = frame_height_q;
   assign frame_count     = frame_count_q;
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_camera_pixel_framer.sv
// Directed bench for camera_pixel_framer: expected beat tables per frame plus hand-written
// sequences for stall, overflow, mid-frame enable, joint hs/vs fall and mid-frame reset.
module tb_camera_pixel_framer;

   typedef struct packed {
      logic       fs;
      logic       fe;
      logic       ls;
      logic       le;
      logic [9:0] y;
      logic [9:0] x;
      logic [9:0] d;
   } beat_t;

   logic        clock, reset, enable, in_vs, in_hs, in_valid, out_ready, clear_overflow;
   logic [9:0]  in_d, out_data, out_x, out_y, line_width, frame_height;
   logic        out_frame_start, out_frame_stop, out_line_start, out_line_stop, out_valid, overflow;
   logic [15:0] frame_count;

   beat_t got[$];
   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   camera_pixel_framer dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .in_vs           (in_vs),
      .in_hs           (in_hs),
      .in_valid        (in_valid),
      .in_d            (in_d),
      .out_data        (out_data),
      .out_x           (out_x),
      .out_y           (out_y),
      .out_frame_start (out_frame_start),
      .out_frame_stop  (out_frame_stop),
      .out_line_start  (out_line_start),
      .out_line_stop   (out_line_stop),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .line_width      (line_width),
      .frame_height    (frame_height),
      .frame_count     (frame_count),
      .overflow        (overflow),
      .clear_overflow  (clear_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record each beat that will transfer at the coming rising edge
   always @(negedge clock) begin
      if (out_valid && out_ready)
         got.push_back({out_frame_start, out_frame_stop, out_line_start, out_line_stop,
                        out_y, out_x, out_data});
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected beats of a w x h frame whose pixel (x,y) carries base + y*w + x
   function automatic void fill_exp(input int w, input int h, input int base);
      beat_t b;
      exp_q.delete();
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            b.fs = (x == 0 && y == 0);
            b.fe = (x == w - 1 && y == h - 1);
            b.ls = (x == 0);
            b.le = (x == w - 1);
            b.y  = 10'(y);
            b.x  = 10'(x);
            b.d  = 10'(base + y * w + x);
            exp_q.push_back(b);
         end
   endfunction

   task automatic check_beats(input string name, input int n);
      check({name, "_count"}, 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++)
         check($sformatf("%s_beat%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
   endtask

   // Frame with a stray in_valid (in_hs low) after each line; optional empty line and joint hs/vs fall
   task automatic send_frame(input int w, input int h, input int base,
                             input bit empty_line, input bit joint_fall);
      in_vs = 1'b1;
      tick();
      tick();
      for (int y = 0; y < h; y++) begin
         in_hs = 1'b1;
         tick();
         for (int x = 0; x < w; x++) begin
            in_valid = 1'b1;
            in_d     = 10'(base + y * w + x);
            tick();
         end
         in_valid = 1'b0;
         if (joint_fall && y == h - 1) begin
            in_hs = 1'b0;
            in_vs = 1'b0;
            tick();
         end else begin
            in_hs = 1'b0;
            tick();
            in_valid = 1'b1;
            in_d     = 10'h3ff;
            tick();
            in_valid = 1'b0;
            if (empty_line && y == 0) begin
               in_hs = 1'b1;
               tick();
               tick();
               in_hs = 1'b0;
               tick();
            end
         end
      end
      in_vs = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; in_vs = 1'b0; in_hs = 1'b0; in_valid = 1'b0;
      in_d = '0; out_ready = 1'b0; clear_overflow = 1'b0;
      tick();
      @(negedge clock);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_line_width", 64'(line_width), 64'd0);
      check("rst_frame_height", 64'(frame_height), 64'd0);
      check("rst_frame_count", 64'(frame_count), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      tick();
      reset = 1'b1;
      enable = 1'b1;
      out_ready = 1'b1;
      repeat (2) tick();

      // 4x3 frame, free-running consumer
      got.delete();
      send_frame(4, 3, 'h100, 1'b0, 1'b0);
      repeat (10) tick();
      fill_exp(4, 3, 'h100);
      check_beats("f4x3", 12);
      check("f4x3_line_width", 64'(line_width), 64'd4);
      check("f4x3_frame_height", 64'(frame_height), 64'd3);
      check("f4x3_frame_count", 64'(frame_count), 64'd1);

      // Same frame with the consumer stalled for 40 cycles
      got.delete();
      out_ready = 1'b0;
      send_frame(4, 3, 'h100, 1'b0, 1'b0);
      repeat (14) tick();
      @(negedge clock);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data", 64'(out_data), 64'h100);
      check("stall_frame_start", 64'(out_frame_start), 64'd1);
      tick();
      out_ready = 1'b1;
      repeat (20) tick();
      check_beats("stall", 12);
      check("stall_overflow", 64'(overflow), 64'd0);
      check("stall_frame_count", 64'(frame_count), 64'd2);

      // 32x16 frame with no consumer: only the first 16 pixels survive
      got.delete();
      out_ready = 1'b0;
      send_frame(32, 16, 0, 1'b0, 1'b0);
      check("ovf_flag", 64'(overflow), 64'd1);
      out_ready = 1'b1;
      repeat (30) tick();
      fill_exp(32, 16, 0);
      check_beats("ovf", 16);
      check("ovf_frame_count", 64'(frame_count), 64'd2);
      check("ovf_sticky", 64'(overflow), 64'd1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check("ovf_cleared", 64'(overflow), 64'd0);

      // Disabled frame, then enable raised while in_vs is already high
      got.delete();
      enable = 1'b0;
      send_frame(4, 3, 'h200, 1'b0, 1'b0);
      repeat (5) tick();
      check("disabled_beats", 64'(got.size()), 64'd0);
      in_vs = 1'b1;
      repeat (2) tick();
      enable = 1'b1;
      in_hs = 1'b1;
      tick();
      for (int x = 0; x < 3; x++) begin
         in_valid = 1'b1;
         in_d     = 10'(x + 'h280);
         tick();
      end
      in_valid = 1'b0;
      in_hs = 1'b0;
      tick();
      in_vs = 1'b0;
      repeat (3) tick();
      repeat (5) tick();
      check("midframe_beats", 64'(got.size()), 64'd0);
      send_frame(2, 2, 'h300, 1'b0, 1'b0);
      repeat (10) tick();
      fill_exp(2, 2, 'h300);
      check_beats("after_enable", 4);
      check("after_enable_frame_count", 64'(frame_count), 64'd3);

      // Joint hs/vs fall with an empty line after the first line
      got.delete();
      send_frame(2, 2, 'h340, 1'b1, 1'b1);
      repeat (10) tick();
      fill_exp(2, 2, 'h340);
      check_beats("joint", 4);
      check("joint_frame_height", 64'(frame_height), 64'd2);
      check("joint_line_width", 64'(line_width), 64'd2);
      check("joint_frame_count", 64'(frame_count), 64'd4);

      // Reset in the middle of a line
      in_vs = 1'b1;
      repeat (2) tick();
      in_hs = 1'b1;
      tick();
      for (int x = 0; x < 3; x++) begin
         in_valid = 1'b1;
         in_d     = 10'(x + 'h3a0);
         tick();
      end
      reset = 1'b0;
      @(negedge clock);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_frame_count", 64'(frame_count), 64'd0);
      check("midrst_line_width", 64'(line_width), 64'd0);
      check("midrst_frame_height", 64'(frame_height), 64'd0);
      in_valid = 1'b0;
      in_hs = 1'b0;
      in_vs = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      got.delete();
      send_frame(4, 3, 'h100, 1'b0, 1'b0);
      repeat (10) tick();
      fill_exp(4, 3, 'h100);
      check_beats("post_rst", 12);
      check("post_rst_frame_count", 64'(frame_count), 64'd1);
      check("post_rst_frame_height", 64'(frame_height), 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
